// File: rtl/cpi_scheduler.sv
// cpi_scheduler
//   Coherent-processing-interval sequencer for the radar pulse-sync path.
//   On start it spends GUARD cycles in ARM (T/R switch pre-raised), then runs
//   CPIs of NUM_PULSES PRIs: NUM_PULSES-1 short PRIs followed by one long PRI.
//   A CPI count of zero runs until stop/abort. stop finishes the current CPI
//   (or the next one if it lands on the last cycle); abort drops to IDLE on
//   the following cycle.
//
// Ports
//   sysclk, rst_n      : clock, asynchronous active-low reset
//   start              : one-cycle start request, honoured in IDLE only
//   stop               : graceful stop request, honoured in ARM/RUN
//   abort              : immediate return to IDLE from any state
//   n_cpi[15:0]        : CPIs to run (0 = continuous), latched on start
//   pmt_sync           : PMT sync pulse, high for PULSE_LEN at each PRI start
//   sw_ctrl            : T/R switch control, rises GUARD cycles ahead of a PMT pulse
//   busy               : high in ARM/RUN
//   pulse_idx          : pulse index within the current CPI
//   cpi_done           : strobe on the last cycle of every CPI
//   cpi_cnt[15:0]      : CPIs completed since the last start, saturating
//
// All outputs are registered. The output registers are loaded from a decode
// of the next-state values, so each output lines up with cnt/pulse_idx of the
// same cycle.

module cpi_scheduler #(
   parameter int PRI_SHORT  = 2400,
   parameter int PRI_LONG   = 3000,
   parameter int PULSE_LEN  = 480,
   parameter int GUARD      = 6,
   parameter int NUM_PULSES = 100,
   parameter int CNT_W      = 12,
   parameter int IDX_W      = 8
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             abort,
   input  logic [15:0]      n_cpi,
   output logic             pmt_sync,
   output logic             sw_ctrl,
   output logic             busy,
   output logic [IDX_W-1:0] pulse_idx,
   output logic             cpi_done,
   output logic [15:0]      cpi_cnt
);

   localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(PRI_SHORT - 1);
   localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(PRI_LONG - 1);
   localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD - 1);
   localparam logic [CNT_W-1:0] SHORT_SW  = CNT_W'(PRI_SHORT - GUARD);
   localparam logic [CNT_W-1:0] LONG_SW   = CNT_W'(PRI_LONG - GUARD);
   localparam logic [CNT_W-1:0] PULSE_CYC = CNT_W'(PULSE_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PULSES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_RUN  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [15:0]      cpi_cnt_q, cpi_cnt_d;
   logic [15:0]      n_cpi_q, n_cpi_d;
   logic             stop_pend_q, stop_pend_d;

   logic             pmt_q, sw_q, busy_q, done_q;
   logic             pmt_d, sw_d, busy_d, done_d;

   logic             last_pulse, pri_end, final_cpi;
   logic [15:0]      cpi_inc_q, cpi_inc_d;
   logic             last_d, final_d;

   // Saturating increment of the completed-CPI count.
   assign cpi_inc_q = (cpi_cnt_q == 16'hFFFF) ? cpi_cnt_q : cpi_cnt_q + 16'd1;
   assign cpi_inc_d = (cpi_cnt_d == 16'hFFFF) ? cpi_cnt_d : cpi_cnt_d + 16'd1;

   assign last_pulse = (idx_q == LAST_IDX);
   assign pri_end    = (cnt_q == (last_pulse ? LONG_END : SHORT_END));
   // The CPI now running is the last one. stop_pend is taken from the register,
   // so a stop arriving on the final cycle of a CPI only ends the next CPI.
   assign final_cpi  = stop_pend_q || ((n_cpi_q != 16'd0) && (cpi_inc_q == n_cpi_q));

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      cpi_cnt_d   = cpi_cnt_q;
      n_cpi_d     = n_cpi_q;
      stop_pend_d = stop_pend_q;

      if (abort) begin
         // cpi_cnt is held: a partial CPI is never counted.
         state_d     = S_IDLE;
         cnt_d       = '0;
         idx_d       = '0;
         stop_pend_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d     = S_ARM;
                  cnt_d       = '0;
                  idx_d       = '0;
                  n_cpi_d     = n_cpi;
                  cpi_cnt_d   = '0;
                  stop_pend_d = 1'b0;
               end
            end
            S_ARM: begin
               if (stop) stop_pend_d = 1'b1;
               if (cnt_q == GUARD_END) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (stop) stop_pend_d = 1'b1;
               if (pri_end) begin
                  cnt_d = '0;
                  if (last_pulse) begin
                     idx_d     = '0;
                     cpi_cnt_d = cpi_inc_q;
                     if (final_cpi) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode of the next state
   // ------------------------------------------------------------------
   assign last_d  = (idx_d == LAST_IDX);
   // Whether the CPI about to run/continue will be the one that ends in IDLE.
   assign final_d = stop_pend_d || ((n_cpi_d != 16'd0) && (cpi_inc_d == n_cpi_d));

   always_comb begin
      busy_d = (state_d != S_IDLE);
      pmt_d  = (state_d == S_RUN) && (cnt_d < PULSE_CYC);
      done_d = (state_d == S_RUN) && last_d && (cnt_d == LONG_END);
      sw_d   = 1'b0;
      case (state_d)
         S_ARM: sw_d = 1'b1;
         S_RUN: begin
            if (last_d)
               // No pre-rise on a CPI that returns to IDLE. Once the guard has
               // started it is held, so a late stop cannot chop it.
               sw_d = (cnt_d >= LONG_SW) && (!final_d || sw_q);
            else if (idx_d[0])
               sw_d = (cnt_d >= SHORT_SW);
            else
               sw_d = 1'b1;
         end
         default: sw_d = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         cpi_cnt_q   <= '0;
         n_cpi_q     <= '0;
         stop_pend_q <= 1'b0;
         pmt_q       <= 1'b0;
         sw_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         cpi_cnt_q   <= cpi_cnt_d;
         n_cpi_q     <= n_cpi_d;
         stop_pend_q <= stop_pend_d;
         pmt_q       <= pmt_d;
         sw_q        <= sw_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pmt_sync  = pmt_q;
   assign sw_ctrl   = sw_q;
   assign busy      = busy_q;
   assign pulse_idx = idx_q;
   assign cpi_done  = done_q;
   assign cpi_cnt   = cpi_cnt_q;

endmodule

// File: tb/tb_cpi_scheduler.sv
// tb_cpi_scheduler
//   Bench for cpi_scheduler with scaled-down timing. Expected output vectors
//   come from a closed-form timeline (cycle offset since start -> CPI, pulse,
//   count) and are queued when a command is driven; each falling edge pops one
//   and compares it with the DUT outputs.

module tb_cpi_scheduler;

   localparam int PS   = 40;   // short PRI
   localparam int PLG  = 50;   // long PRI
   localparam int PLEN = 8;    // PMT pulse length
   localparam int G    = 3;    // guard
   localparam int NP   = 4;    // pulses per CPI
   localparam int CW   = 6;
   localparam int IW   = 2;
   localparam int CL   = (NP - 1) * PS + PLG;  // cycles per CPI

   logic          sysclk = 1'b0;
   logic          rst_n  = 1'b1;
   logic          start  = 1'b0;
   logic          stop   = 1'b0;
   logic          abort  = 1'b0;
   logic [15:0]   n_cpi  = '0;
   logic          pmt_sync, sw_ctrl, busy, cpi_done;
   logic [IW-1:0] pulse_idx;
   logic [15:0]   cpi_cnt;

   bit clk_en = 1'b1;

   always begin
      #5;
      if (clk_en) sysclk = ~sysclk;
   end

   cpi_scheduler #(
      .PRI_SHORT (PS),
      .PRI_LONG  (PLG),
      .PULSE_LEN (PLEN),
      .GUARD     (G),
      .NUM_PULSES(NP),
      .CNT_W     (CW),
      .IDX_W     (IW)
   ) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .abort    (abort),
      .n_cpi    (n_cpi),
      .pmt_sync (pmt_sync),
      .sw_ctrl  (sw_ctrl),
      .busy     (busy),
      .pulse_idx(pulse_idx),
      .cpi_done (cpi_done),
      .cpi_cnt  (cpi_cnt)
   );

   typedef struct packed {
      logic          busy;
      logic          pmt;
      logic          sw;
      logic          done;
      logic [IW-1:0] idx;
      logic [15:0]   cnt;
   } obs_t;

   obs_t q[$];
   int   nchk = 0;
   int   nerr = 0;
   int   kcur = -1;

   function automatic obs_t cur();
      obs_t o;
      o.busy = busy;
      o.pmt  = pmt_sync;
      o.sw   = sw_ctrl;
      o.done = cpi_done;
      o.idx  = pulse_idx;
      o.cnt  = cpi_cnt;
      return o;
   endfunction

   function automatic obs_t idle_obs(int c);
      obs_t o = '0;
      o.cnt = 16'(c);
      return o;
   endfunction

   // Expected outputs k cycles after the start edge for a run of nrun CPIs.
   function automatic obs_t model(int k, int nrun);
      obs_t o = '0;
      int r, c, off, idx, cnt;
      if (k < G) begin
         o.busy = 1'b1;
         o.sw   = 1'b1;
         return o;
      end
      r = k - G;
      c = r / CL;
      if (c >= nrun) return idle_obs(nrun);
      off = r % CL;
      if (off < (NP - 1) * PS) begin
         idx = off / PS;
         cnt = off % PS;
      end else begin
         idx = NP - 1;
         cnt = off - (NP - 1) * PS;
      end
      o.busy = 1'b1;
      o.idx  = IW'(idx);
      o.cnt  = 16'(c);
      o.pmt  = (cnt < PLEN);
      o.done = (idx == NP - 1) && (cnt == PLG - 1);
      if (idx == NP - 1)      o.sw = (c != nrun - 1) && (cnt >= PLG - G);
      else if (idx % 2 == 1)  o.sw = (cnt >= PS - G);
      else                    o.sw = 1'b1;
      return o;
   endfunction

   task automatic chk(input string tag, input obs_t got, input obs_t exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got busy=%b pmt=%b sw=%b done=%b idx=%0d cpi_cnt=%0d, want busy=%b pmt=%b sw=%b done=%b idx=%0d cpi_cnt=%0d",
                  tag, got.busy, got.pmt, got.sw, got.done, got.idx, got.cnt,
                  exp.busy, exp.pmt, exp.sw, exp.done, exp.idx, exp.cnt);
      end
   endtask

   task automatic tick(input string tag);
      obs_t e;
      @(negedge sysclk);
      if (q.size() > 0) begin
         e = q.pop_front();
         kcur++;
         chk($sformatf("%s k=%0d", tag, kcur), cur(), e);
      end
   endtask

   task automatic drain(input string tag);
      while (q.size() > 0) tick(tag);
   endtask

   task automatic wait_k(input string tag, input int k);
      while (kcur < k && q.size() > 0) tick(tag);
   endtask

   task automatic push_idle(input int n, input int c);
      for (int i = 0; i < n; i++) q.push_back(idle_obs(c));
   endtask

   // Issue a start and queue the whole expected timeline plus idle tail.
   task automatic launch(input string tag, input int n, input int nrun, input int tail);
      q.delete();
      for (int k = 0; k < G + nrun * CL + tail; k++) q.push_back(model(k, nrun));
      kcur  = -1;
      start = 1'b1;
      n_cpi = 16'(n);
      tick(tag);
      start = 1'b0;
   endtask

   task automatic pulse_stop(input string tag);
      stop = 1'b1;
      tick(tag);
      stop = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2 chk("reset", cur(), idle_obs(0));
      @(negedge sysclk);
      rst_n = 1'b1;

      // single CPI
      launch("one_cpi", 1, 1, 4);
      drain("one_cpi");

      // two CPIs: switch pre-rise only on the CPI that does not end in IDLE
      launch("two_cpi", 2, 2, 4);
      drain("two_cpi");

      // continuous, stop in CPI 3 pulse 1
      launch("cont_stop", 0, 3, 4);
      wait_k("cont_stop", G + 2 * CL + PS + 10);
      pulse_stop("cont_stop");
      drain("cont_stop");

      // stop during ARM still runs a full CPI
      launch("arm_stop", 0, 1, 4);
      pulse_stop("arm_stop");
      drain("arm_stop");

      // stop on the last cycle of CPI 1 ends after CPI 2
      launch("last_stop", 0, 2, 4);
      wait_k("last_stop", G + CL - 1);
      pulse_stop("last_stop");
      drain("last_stop");

      // abort in CPI 1, then restart with abort in CPI 2, then a clean run
      launch("abort1", 1, 1, 0);
      wait_k("abort1", G + 2 * PS + 5);
      q.delete();
      push_idle(5, 0);
      abort = 1'b1;
      tick("abort1");
      abort = 1'b0;
      drain("abort1");

      launch("abort2", 2, 2, 0);
      wait_k("abort2", G + CL + PS + 7);
      q.delete();
      push_idle(5, 1);
      abort = 1'b1;
      tick("abort2");
      abort = 1'b0;
      drain("abort2");

      launch("restart", 1, 1, 4);
      drain("restart");

      // start while busy is ignored
      launch("busy_start", 1, 1, 4);
      wait_k("busy_start", G + PS + 3);
      start = 1'b1;
      n_cpi = 16'd7;
      tick("busy_start");
      start = 1'b0;
      drain("busy_start");

      // start+abort in IDLE and stop in IDLE do nothing
      q.delete();
      push_idle(6, 1);
      start = 1'b1;
      abort = 1'b1;
      n_cpi = 16'd3;
      tick("idle_cmds");
      start = 1'b0;
      abort = 1'b0;
      pulse_stop("idle_cmds");
      drain("idle_cmds");

      // asynchronous reset mid-run with the clock stopped
      launch("async_rst", 1, 1, 0);
      wait_k("async_rst", G + 2 * PS + 20);
      clk_en = 1'b0;
      q.delete();
      #2 rst_n = 1'b0;
      #1 chk("async_rst", cur(), idle_obs(0));
      #4 rst_n = 1'b1;
      clk_en = 1'b1;
      push_idle(5, 0);
      drain("post_rst");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
